// File: rtl/aesl_deadlock_multi_monitor.sv
// Deadlock monitor for one HLS instance. It combines the AXIS stall flags, the child monitor
// block flags and the instance block/idle flags into a single debounced block output.
// The combined condition must hold for HOLD_CYCLES cycles in a row before block asserts.
// A sticky flag and the first blocking channel index are kept until clear.
// Ports:
//   clock, reset           : sole clock (rising edge) and asynchronous active-low reset
//   axis_block_sigs        : per-channel AXIS stall flags
//   inst_idle_sigs         : instance idle flags
//   inst_block_sigs        : instance internal block flags
//   sub_block_sigs         : block outputs of child monitors
//   clear                  : one-cycle pulse that clears block_sticky and block_chan
//   block, block_sticky    : debounced block indication and its sticky copy
//   block_chan, hold_cnt   : captured lowest blocking channel and the debug run-length counter
// Optional feature macro AESL_DEADLOCK_SNAPSHOT_EN adds snap_axis/snap_cycle, which record
// the stall pattern and a free-running cycle count at each entry into the blocked state.
module aesl_deadlock_multi_monitor #(
  parameter int                NUM_AXIS     = 1,
  parameter int                NUM_INST     = 1,
  parameter int                NUM_SUB      = 1,
  parameter logic [NUM_SUB-1:0] SUB_PAR_MASK = '0,
  parameter int                HOLD_CYCLES  = 1,
  parameter int                CNT_W        = 8,
  parameter int                IDX_W        = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic [NUM_SUB-1:0]  sub_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic                block_sticky,
  output logic [IDX_W-1:0]    block_chan,
  output logic [CNT_W-1:0]    hold_cnt
`ifdef AESL_DEADLOCK_SNAPSHOT_EN
  ,
  output logic [NUM_AXIS-1:0] snap_axis,
  output logic [31:0]         snap_cycle
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SUSPECT = 2'd1;
  localparam logic [1:0] ST_BLOCKED = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   HOLD_VAL = (CNT_W+1)'(HOLD_CYCLES);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             par;
  logic             sgl;
  logic             axis;
  logic             all_idle;
  logic             cond;
  logic             entry;
  logic [IDX_W-1:0] first_idx;

  // Parallel children block only when every one of them blocks; single children block alone.
  // An empty parallel group must never contribute, hence the |SUB_PAR_MASK gate.
  assign par      = (|SUB_PAR_MASK) & (&(sub_block_sigs | ~SUB_PAR_MASK));
  assign sgl      = |(sub_block_sigs & ~SUB_PAR_MASK);
  assign axis     = (|axis_block_sigs) | (|inst_block_sigs);
  assign all_idle = &inst_idle_sigs;
  // A fully idle instance is never considered deadlocked.
  assign cond     = (par | sgl | axis) & ~all_idle;

  // Lowest set stall bit; scanning downward lets the lowest index win.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (axis_block_sigs[i]) first_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (cond) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = (HOLD_CYCLES == 1) ? ST_BLOCKED : ST_SUSPECT;
        end else begin
          cnt_nxt = '0;
        end
      end
      ST_SUSPECT: begin
        if (!cond) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = hold_cnt + CNT_W'(1);
          if (({1'b0, hold_cnt} + (CNT_W+1)'(1)) == HOLD_VAL) state_nxt = ST_BLOCKED;
        end
      end
      ST_BLOCKED: begin
        if (!cond) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (hold_cnt != CNT_MAX) begin
          cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign entry = (state != ST_BLOCKED) && (state_nxt == ST_BLOCKED);
  assign block = (state == ST_BLOCKED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= cnt_nxt;
    end
  end

  // Entry takes priority over a coincident clear: the flag stays set and the index is
  // freshly captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      block_sticky <= 1'b0;
      block_chan   <= '0;
    end else if (entry) begin
      block_sticky <= 1'b1;
      if (!block_sticky || clear) block_chan <= first_idx;
    end else if (clear) begin
      block_sticky <= 1'b0;
      block_chan   <= '0;
    end
  end

`ifdef AESL_DEADLOCK_SNAPSHOT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt  <= '0;
      snap_axis  <= '0;
      snap_cycle <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (entry) begin
        snap_axis  <= axis_block_sigs;
        snap_cycle <= cycle_cnt;
      end else if (clear) begin
        snap_axis  <= '0;
        snap_cycle <= '0;
      end
    end
  end
`endif

endmodule
